// File: rtl/cross_bar_mem_responder.sv
// cross_bar_mem_responder
//   Memory-backed responder terminating one crossbar master-side port.
//   Writes update an internal word array at the transfer edge. Reads sample
//   the array at the transfer edge and return the word RD_LATENCY cycles later
//   as a one-cycle resp pulse.
//
// Ports
//   aclk, aresetn        clock (rising edge), async active-low reset
//   req, addr, cmd, wdata request valid, byte address, 0=read/1=write, write data
//   ack                  registered accept; transfer = req && ack at an edge
//   rdata, resp          read data (valid while resp=1, held otherwise), response pulse
//   rd_cnt, wr_cnt       saturating counts of accepted reads / writes
//
// Optional build macro: CROSS_BAR_MEM_RESPONDER_STALL_EN
//   When defined, a 4-bit free-running counter drops ack for one cycle in four.
module cross_bar_mem_responder #(
  parameter int AWIDTH     = 32,
  parameter int DWIDTH     = 32,
  parameter int DEPTH      = 256,
  parameter int RD_LATENCY = 2
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic              req,
  input  logic [AWIDTH-1:0] addr,
  input  logic              cmd,
  input  logic [DWIDTH-1:0] wdata,
  output logic              ack,
  output logic [DWIDTH-1:0] rdata,
  output logic              resp,
  output logic [15:0]       rd_cnt,
  output logic [15:0]       wr_cnt
);

  localparam int B  = $clog2(DWIDTH / 8);
  localparam int IW = $clog2(DEPTH);

  logic [DWIDTH-1:0] mem [DEPTH];

  logic [IW-1:0]     idx;
  logic              wr_xfer;
  logic              rd_xfer;
  logic              ack_q, ack_d;
  logic [15:0]       rd_cnt_q, rd_cnt_d;
  logic [15:0]       wr_cnt_q, wr_cnt_d;
  logic              vld_q [RD_LATENCY];
  logic              vld_d [RD_LATENCY];
  logic [DWIDTH-1:0] dat_q [RD_LATENCY];
  logic [DWIDTH-1:0] dat_d [RD_LATENCY];

`ifdef CROSS_BAR_MEM_RESPONDER_STALL_EN
  logic [3:0]        stall_cnt_q, stall_cnt_d;
`endif

  // Upper and lower address bits are intentionally ignored (word aliasing).
  logic unused_addr;
  assign unused_addr = ^addr;

  assign idx = addr[B +: IW];

  always_comb begin
    wr_xfer = req && ack_q && cmd;
    rd_xfer = req && ack_q && !cmd;

`ifdef CROSS_BAR_MEM_RESPONDER_STALL_EN
    stall_cnt_d = stall_cnt_q + 4'd1;
    // ack is registered, so it reflects the counter value it is loaded with.
    ack_d       = (stall_cnt_d[1:0] != 2'b11);
`else
    ack_d       = 1'b1;
`endif

    rd_cnt_d = rd_cnt_q;
    if (rd_xfer && (rd_cnt_q != 16'hFFFF)) rd_cnt_d = rd_cnt_q + 16'd1;
    wr_cnt_d = wr_cnt_q;
    if (wr_xfer && (wr_cnt_q != 16'hFFFF)) wr_cnt_d = wr_cnt_q + 16'd1;

    // Data in a stage only moves with a valid token, so the last stage (rdata)
    // holds its value through bubbles instead of shifting stale data out.
    vld_d[0] = rd_xfer;
    dat_d[0] = rd_xfer ? mem[idx] : dat_q[0];
    for (int unsigned i = 1; i < RD_LATENCY; i++) begin
      vld_d[i] = vld_q[i-1];
      dat_d[i] = vld_q[i-1] ? dat_q[i-1] : dat_q[i];
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      ack_q    <= 1'b0;
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
      for (int unsigned i = 0; i < RD_LATENCY; i++) begin
        vld_q[i] <= 1'b0;
        dat_q[i] <= '0;
      end
`ifdef CROSS_BAR_MEM_RESPONDER_STALL_EN
      stall_cnt_q <= '0;
`endif
    end else begin
      ack_q    <= ack_d;
      rd_cnt_q <= rd_cnt_d;
      wr_cnt_q <= wr_cnt_d;
      for (int unsigned i = 0; i < RD_LATENCY; i++) begin
        vld_q[i] <= vld_d[i];
        dat_q[i] <= dat_d[i];
      end
`ifdef CROSS_BAR_MEM_RESPONDER_STALL_EN
      stall_cnt_q <= stall_cnt_d;
`endif
    end
  end

  // Array contents are not reset.
  always_ff @(posedge aclk) begin
    if (wr_xfer) mem[idx] <= wdata;
  end

  assign ack    = ack_q;
  assign resp   = vld_q[RD_LATENCY-1];
  assign rdata  = dat_q[RD_LATENCY-1];
  assign rd_cnt = rd_cnt_q;
  assign wr_cnt = wr_cnt_q;

endmodule

// File: tb/tb_cross_bar_mem_responder.sv
module tb_cross_bar_mem_responder;

  logic        aclk;
  logic        aresetn;
  logic        req;
  logic [31:0] addr;
  logic        cmd;
  logic [31:0] wdata;
  logic        ack;
  logic [31:0] rdata;
  logic        resp;
  logic [15:0] rd_cnt;
  logic [15:0] wr_cnt;

  int total = 0;
  int bad   = 0;
  logic [15:0] exp_rd;
  logic [15:0] exp_wr;

  cross_bar_mem_responder #(
    .AWIDTH(32),
    .DWIDTH(32),
    .DEPTH(256),
    .RD_LATENCY(2)
  ) dut (
    .aclk(aclk),
    .aresetn(aresetn),
    .req(req),
    .addr(addr),
    .cmd(cmd),
    .wdata(wdata),
    .ack(ack),
    .rdata(rdata),
    .resp(resp),
    .rd_cnt(rd_cnt),
    .wr_cnt(wr_cnt)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  task automatic test_reset();
    aresetn = 1'b0;
    repeat (5) @(negedge aclk);
    total++; if (ack !== 1'b0) begin bad++; $display("FAIL rst_ack: got %0b want 0", ack); end
    total++; if (resp !== 1'b0) begin bad++; $display("FAIL rst_resp: got %0b want 0", resp); end
    total++; if (rdata !== 32'h0) begin bad++; $display("FAIL rst_rdata: got %h want 0", rdata); end
    total++; if (rd_cnt !== 16'h0) begin bad++; $display("FAIL rst_rd_cnt: got %0d want 0", rd_cnt); end
    total++; if (wr_cnt !== 16'h0) begin bad++; $display("FAIL rst_wr_cnt: got %0d want 0", wr_cnt); end
    aresetn = 1'b1;
    exp_rd = 16'd0;
    exp_wr = 16'd0;
    #1;
    total++; if (ack !== 1'b0) begin bad++; $display("FAIL rel_ack_first: got %0b want 0", ack); end
    @(negedge aclk);
    total++; if (ack !== 1'b1) begin bad++; $display("FAIL rel_ack_after: got %0b want 1", ack); end
    total++; if (resp !== 1'b0) begin bad++; $display("FAIL rel_resp: got %0b want 0", resp); end
  endtask

  task automatic test_write_read();
    @(negedge aclk);
    total++; if (ack !== 1'b1) begin bad++; $display("FAIL wr_ack: got %0b want 1", ack); end
    req = 1'b1; cmd = 1'b1; addr = 32'h10; wdata = 32'hDEADBEEF;
    @(negedge aclk);
    exp_wr = exp_wr + 16'd1;
    cmd = 1'b0;
    @(negedge aclk);
    exp_rd = exp_rd + 16'd1;
    req = 1'b0;
    total++; if (resp !== 1'b0) begin bad++; $display("FAIL wr_rd_early: got %0b want 0", resp); end
    @(negedge aclk);
    total++; if (resp !== 1'b1) begin bad++; $display("FAIL wr_rd_resp: got %0b want 1", resp); end
    total++; if (rdata !== 32'hDEADBEEF) begin bad++; $display("FAIL wr_rd_data: got %h want deadbeef", rdata); end
    @(negedge aclk);
    total++; if (resp !== 1'b0) begin bad++; $display("FAIL wr_rd_single: got %0b want 0", resp); end
    total++; if (rdata !== 32'hDEADBEEF) begin bad++; $display("FAIL wr_rd_hold: got %h want deadbeef", rdata); end
    total++; if (wr_cnt !== exp_wr) begin bad++; $display("FAIL wr_rd_wr_cnt: got %0d want %0d", wr_cnt, exp_wr); end
    total++; if (rd_cnt !== exp_rd) begin bad++; $display("FAIL wr_rd_rd_cnt: got %0d want %0d", rd_cnt, exp_rd); end
  endtask

  task automatic test_alias_order();
    logic        op_cmd  [7] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [31:0] op_addr [7] = '{32'h0, 32'h400, 32'h4, 32'h0, 32'h4, 32'h4, 32'h4};
    logic [31:0] op_data [7] = '{32'h11, 32'h22, 32'h44, 32'h0, 32'h0, 32'h55, 32'h0};
    logic        want_resp;
    logic [31:0] want_data;
    for (int c = 0; c < 10; c++) begin
      @(negedge aclk);
      want_resp = 1'b0;
      want_data = 32'h0;
      case (c)
        5: begin want_resp = 1'b1; want_data = 32'h22; end
        6: begin want_resp = 1'b1; want_data = 32'h44; end
        8: begin want_resp = 1'b1; want_data = 32'h55; end
        default: ;
      endcase
      total++;
      if (resp !== want_resp) begin bad++; $display("FAIL alias_resp c=%0d: got %0b want %0b", c, resp, want_resp); end
      if (want_resp) begin
        total++;
        if (rdata !== want_data) begin bad++; $display("FAIL alias_data c=%0d: got %h want %h", c, rdata, want_data); end
      end
      if (c < 7) begin
        req = 1'b1; cmd = op_cmd[c]; addr = op_addr[c]; wdata = op_data[c];
        if (op_cmd[c]) exp_wr = exp_wr + 16'd1;
        else           exp_rd = exp_rd + 16'd1;
      end else begin
        req = 1'b0;
      end
    end
    total++; if (wr_cnt !== exp_wr) begin bad++; $display("FAIL alias_wr_cnt: got %0d want %0d", wr_cnt, exp_wr); end
    total++; if (rd_cnt !== exp_rd) begin bad++; $display("FAIL alias_rd_cnt: got %0d want %0d", rd_cnt, exp_rd); end
  endtask

  task automatic test_back_to_back();
    for (int c = 0; c < 18; c++) begin
      @(negedge aclk);
      total++;
      if (resp !== (c >= 10)) begin bad++; $display("FAIL b2b_resp c=%0d: got %0b want %0b", c, resp, (c >= 10)); end
      if (c >= 10) begin
        total++;
        if (rdata !== 32'h100 + 32'(c - 10)) begin
          bad++; $display("FAIL b2b_data c=%0d: got %h want %h", c, rdata, 32'h100 + 32'(c - 10));
        end
      end
      if (c < 8) begin
        req = 1'b1; cmd = 1'b1; addr = 32'(c * 4); wdata = 32'h100 + 32'(c);
        exp_wr = exp_wr + 16'd1;
      end else if (c < 16) begin
        req = 1'b1; cmd = 1'b0; addr = 32'((c - 8) * 4);
        exp_rd = exp_rd + 16'd1;
      end else begin
        req = 1'b0;
      end
    end
    @(negedge aclk);
    total++; if (resp !== 1'b0) begin bad++; $display("FAIL b2b_end_resp: got %0b want 0", resp); end
    total++; if (rdata !== 32'h107) begin bad++; $display("FAIL b2b_hold: got %h want 107", rdata); end
    total++; if (rd_cnt !== exp_rd) begin bad++; $display("FAIL b2b_rd_cnt: got %0d want %0d", rd_cnt, exp_rd); end
    total++; if (wr_cnt !== exp_wr) begin bad++; $display("FAIL b2b_wr_cnt: got %0d want %0d", wr_cnt, exp_wr); end
  endtask

  task automatic test_reset_midflight();
    @(negedge aclk);
    req = 1'b1; cmd = 1'b0; addr = 32'h10;
    @(negedge aclk);
    req = 1'b0;
    aresetn = 1'b0;
    #1;
    total++; if (resp !== 1'b0) begin bad++; $display("FAIL mid_rst_resp: got %0b want 0", resp); end
    total++; if (rd_cnt !== 16'h0) begin bad++; $display("FAIL mid_rst_rd_cnt: got %0d want 0", rd_cnt); end
    total++; if (wr_cnt !== 16'h0) begin bad++; $display("FAIL mid_rst_wr_cnt: got %0d want 0", wr_cnt); end
    total++; if (ack !== 1'b0) begin bad++; $display("FAIL mid_rst_ack: got %0b want 0", ack); end
    repeat (2) @(negedge aclk);
    aresetn = 1'b1;
    exp_rd = 16'd0;
    exp_wr = 16'd0;
    for (int c = 0; c < 6; c++) begin
      @(negedge aclk);
      total++;
      if (resp !== 1'b0) begin bad++; $display("FAIL mid_no_resp c=%0d: got %0b want 0", c, resp); end
    end
    total++; if (rd_cnt !== 16'h0) begin bad++; $display("FAIL mid_rd_cnt: got %0d want 0", rd_cnt); end
    total++; if (rdata !== 32'h0) begin bad++; $display("FAIL mid_rdata: got %h want 0", rdata); end
  endtask

  task automatic test_stall();
    int idx = 0;
    int ri = 0;
    int got = 0;
    int lows = 0;
    int last_low = -1;
    int cyc = 0;
    while (idx < 8 && cyc < 40) begin
      @(negedge aclk);
      cyc++;
      if (ack !== 1'b1) begin
        lows++;
        if (last_low >= 0) begin
          total++;
          if (cyc - last_low != 4) begin bad++; $display("FAIL stall_spacing: got %0d want 4", cyc - last_low); end
        end
        last_low = cyc;
      end
      req = 1'b1; cmd = 1'b1; addr = 32'(idx * 4); wdata = 32'h200 + 32'(idx);
      if (ack === 1'b1) idx++;
    end
    @(negedge aclk);
    req = 1'b0;
    total++; if (idx != 8) begin bad++; $display("FAIL stall_writes_done: got %0d want 8", idx); end
    total++; if (lows < 2) begin bad++; $display("FAIL stall_lows: got %0d want >=2", lows); end
    total++; if (wr_cnt !== 16'd8) begin bad++; $display("FAIL stall_wr_cnt: got %0d want 8", wr_cnt); end
    cyc = 0;
    while (got < 8 && cyc < 60) begin
      @(negedge aclk);
      cyc++;
      if (resp === 1'b1) begin
        total++;
        if (rdata !== 32'h200 + 32'(got)) begin
          bad++; $display("FAIL stall_rdata %0d: got %h want %h", got, rdata, 32'h200 + 32'(got));
        end
        got++;
      end
      if (ri < 8) begin
        req = 1'b1; cmd = 1'b0; addr = 32'(ri * 4);
        if (ack === 1'b1) ri++;
      end else begin
        req = 1'b0;
      end
    end
    req = 1'b0;
    total++; if (got != 8) begin bad++; $display("FAIL stall_reads_done: got %0d want 8", got); end
    total++; if (rd_cnt !== 16'd8) begin bad++; $display("FAIL stall_rd_cnt: got %0d want 8", rd_cnt); end
  endtask

  initial begin
    aresetn = 1'b0;
    req     = 1'b0;
    cmd     = 1'b0;
    addr    = '0;
    wdata   = '0;
    exp_rd  = '0;
    exp_wr  = '0;
    test_reset();
`ifdef CROSS_BAR_MEM_RESPONDER_STALL_EN
    test_stall();
`else
    test_write_read();
    test_alias_order();
    test_back_to_back();
    test_reset_midflight();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/cross_bar_mem_responder.md
Name: cross_bar_mem_responder

Overview:
- Memory-backed target that terminates one crossbar master-side port (m00/m01): the responder end of the req/ack/resp protocol the crossbar drives.
- Accepts read/write requests, stores writes in an internal word array and returns read data after a fixed pipelined latency.
- Used as the downstream model/endpoint behind each crossbar master port in subsystem sims and FPGA bring-up.

Parameters:
- AWIDTH, 32, request address width in bits.
- DWIDTH, 32, data width in bits; multiple of 8.
- DEPTH, 256, number of DWIDTH words in the array; power of 2, at least 2.
- RD_LATENCY, 2, cycles from read acceptance to resp pulse; range 1..8.

Ports:
- aclk  in  1  clock, all logic on rising edge.
- aresetn  in  1  asynchronous active-low reset.
- req  in  1  request valid from crossbar master port.
- addr  in  AWIDTH  byte address.
- cmd  in  1  0 = read, 1 = write.
- wdata  in  DWIDTH  write data.
- ack  out  1  request accepted when req && ack at a rising edge.
- rdata  out  DWIDTH  read data, valid only while resp = 1.
- resp  out  1  one-cycle read-response pulse.
- rd_cnt  out  16  count of accepted reads, saturating at 16'hFFFF.
- wr_cnt  out  16  count of accepted writes, saturating at 16'hFFFF.

Behaviour:
- Reset (aresetn low, async): ack = 0, resp = 0, rdata = 0, rd_cnt = 0, wr_cnt = 0, pipeline valid bits cleared. Array contents are not reset.
- Word index = addr[B +: log2(DEPTH)], where B = log2(DWIDTH/8). Upper address bits are ignored, so addresses alias modulo DEPTH words. Low B bits are ignored.
- ack is registered and combinationally independent of req. ack = 1 in every cycle after reset release, except when the stall feature forces it low.
- Transfer = req && ack at an edge. The requester holds req/addr/cmd/wdata stable until the transfer; back-to-back transfers every cycle are legal.
- Write transfer: array word updated at that edge. wr_cnt increments. No resp is generated.
- Read transfer: array word sampled at that edge into pipeline stage 1 with valid = 1. rd_cnt increments.
- Pipeline: RD_LATENCY stages of {valid, data} shift every cycle with no backpressure. The last stage drives resp and rdata.
  - The read accepted at edge N produces resp = 1 in the cycle following edge N + RD_LATENCY - 1.
  - For RD_LATENCY = 1, resp is high the cycle right after acceptance.
- Ordering:
  - A write at edge N followed by a read of the same word at edge N+1 returns the new data.
  - A read at edge N followed by a write at edge N+1 returns the old data.
- Up to RD_LATENCY reads may be in flight. Responses return strictly in acceptance order, one per cycle for back-to-back reads.
- rdata is held at its last value when resp = 0 (no bubble zeroing).
- Counters saturate and do not wrap.
- Reset asserted mid-operation: in-flight reads are discarded, and no resp is issued for them after release.
- First edge after release: ack goes to 1, so the earliest transfer is at the second edge after release.

Optional Feature:
- Macro CROSS_BAR_MEM_RESPONDER_STALL_EN.
- Defined:
  - A 4-bit free-running counter, reset 0, increments every cycle.
  - ack is driven low in every cycle in which counter[1:0] == 2'b11, giving a 1-in-4 backpressure pattern.
  - A pending req must then be held to the next ack-high cycle.
- Not defined: counter absent; ack constant 1 after reset release.
- All other behaviour is identical in both builds.

Test Plan:
- Reset then idle: aresetn low 5 cycles, release -> ack = 0 on first cycle, 1 afterwards; resp = 0, rd_cnt = wr_cnt = 0.
- Write 0xDEADBEEF to addr 0x10, then read addr 0x10 the next cycle (RD_LATENCY = 2) -> resp pulses exactly once, 2 cycles after read acceptance, with rdata = 0xDEADBEEF; wr_cnt = 1, rd_cnt = 1.
- Alias and order: write 0x11 to addr 0x0, 0x22 to addr 0x400 (DEPTH = 256, DWIDTH = 32), then read addr 0x0 -> rdata = 0x22. Read 0x4 then write 0x55 to 0x4 on the next cycle -> first read returns the old value.
- Back-to-back reads of words 0..7 on consecutive cycles after writing value = 0x100 + index -> 8 consecutive resp cycles with rdata 0x100..0x107 in order.
- Reset mid-flight: accept a read, assert aresetn at the next edge, release -> no resp ever appears for that read; counters = 0.
- With CROSS_BAR_MEM_RESPONDER_STALL_EN: req held high with 8 writes queued -> exactly 1 of every 4 cycles has ack = 0; all 8 writes land; wr_cnt = 8.
